// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB types and constants for the decode/mux slice
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_e;

  localparam logic [1:0] HRESP_OKAY  = 2'd0;
  localparam logic [1:0] HRESP_ERROR = 2'd1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  // NONSEQ and SEQ are the only transfer types that demand a real response
  function automatic logic htrans_active(input logic [1:0] t);
    return (t == NONSEQ) || (t == SEQ);
  endfunction

endpackage

// File: rtl/ahb_decode_mux_if.sv
// rtl/ahb_decode_mux_if.sv - bus bundle between master, decoder and slave bank
interface ahb_decode_mux_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int HRESP_W = 2
);

  logic [ADDR_W-1:0]          HADDR;
  logic [1:0]                 HTRANS;
  logic [NUM_SLV-1:0]         HSEL_S;
  logic [NUM_SLV-1:0]         HREADYOUT_S;
  logic [NUM_SLV*HRESP_W-1:0] HRESP_S;
  logic [NUM_SLV*DATA_W-1:0]  HRDATA_S;
  logic                       HREADY;
  logic [HRESP_W-1:0]         HRESP;
  logic [DATA_W-1:0]          HRDATA;

  // environment side: master address phase plus slave-bank responses
  modport master (
    output HADDR, HTRANS, HREADYOUT_S, HRESP_S, HRDATA_S,
    input  HSEL_S, HREADY, HRESP, HRDATA
  );

  // decoder side
  modport slave (
    input  HADDR, HTRANS, HREADYOUT_S, HRESP_S, HRDATA_S,
    output HSEL_S, HREADY, HRESP, HRDATA
  );

endinterface

// File: rtl/ahb_default_slave.sv
// rtl/ahb_default_slave.sv - two-cycle ERROR responder for unmapped accesses
module ahb_default_slave
  import ahb_pkg::*;
#(
  parameter int HRESP_W = 2,
  parameter int CNT_W   = 16
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic               HREADY,
  input  logic               miss_active,
  input  logic               err_cnt_clr,
  output logic               ds_hready,
  output logic [HRESP_W-1:0] ds_hresp,
  output logic [CNT_W-1:0]   err_cnt
);

  ds_state_e state, state_nxt;
  logic      enter_err;

  // state register
  always_ff @(posedge HCLK) begin
    if (HRESET) state <= DS_IDLE;
    else        state <= state_nxt;
  end

  // next state; a new address phase is only sampled while HREADY is high
  always_comb begin
    state_nxt = state;
    enter_err = 1'b0;
    case (state)
      DS_IDLE: begin
        if (HREADY && miss_active) begin
          state_nxt = DS_ERR1;
          enter_err = 1'b1;
        end
      end
      DS_ERR1: state_nxt = DS_ERR2;
      DS_ERR2: begin
        if (HREADY && miss_active) begin
          state_nxt = DS_ERR1;
          enter_err = 1'b1;
        end else if (HREADY) begin
          state_nxt = DS_IDLE;
        end
      end
      default: state_nxt = DS_IDLE;
    endcase
  end

  // Moore outputs kept off HREADY so the global ready path has no loop
  assign ds_hready = (state != DS_ERR1);
  assign ds_hresp  = (state == DS_IDLE) ? HRESP_W'(HRESP_OKAY) : HRESP_W'(HRESP_ERROR);

  // saturating decode-error counter; clear beats a same-cycle increment
  always_ff @(posedge HCLK) begin
    if (HRESET)                          err_cnt <= '0;
    else if (err_cnt_clr)                err_cnt <= '0;
    else if (enter_err && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
  end

endmodule

// File: rtl/ahb_decode_mux.sv
// rtl/ahb_decode_mux.sv - N-slave AHB address decoder and response multiplexer
module ahb_decode_mux
  import ahb_pkg::*;
#(
  parameter int                      ADDR_W   = 32,
  parameter int                      DATA_W   = 32,
  parameter int                      NUM_SLV  = 4,
  parameter int                      HRESP_W  = 2,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = '0,
  parameter int                      CNT_W    = 16
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  ahb_decode_mux_if.slave        bus,
  output logic [CNT_W-1:0]       err_cnt,
  input  logic                   err_cnt_clr
);

  // slave indices 0..NUM_SLV-1, the default slave takes the next code
  localparam int                SEL_W       = $clog2(NUM_SLV + 1);
  localparam logic [SEL_W-1:0]  SEL_DEFAULT = SEL_W'(NUM_SLV);

  logic [SEL_W-1:0]   dec_sel;
  logic [SEL_W-1:0]   dp_sel;
  logic               miss_active;
  logic               ds_hready;
  logic [HRESP_W-1:0] ds_hresp;

  // address decode; scanning downward lets the lowest-index hit win
  always_comb begin
    dec_sel = SEL_DEFAULT;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if ((SLV_MASK[i*ADDR_W +: ADDR_W] != '0) &&
          ((bus.HADDR & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]))
        dec_sel = SEL_W'(i);
    end
  end

  // one-hot selects, driven regardless of HTRANS
  always_comb begin
    bus.HSEL_S = '0;
    for (int i = 0; i < NUM_SLV; i++)
      bus.HSEL_S[i] = (dec_sel == SEL_W'(i));
  end

  assign miss_active = (dec_sel == SEL_DEFAULT) && htrans_active(bus.HTRANS);

  // data-phase owner follows the accepted address phase
  always_ff @(posedge HCLK) begin
    if (HRESET)          dp_sel <= SEL_DEFAULT;
    else if (bus.HREADY) dp_sel <= dec_sel;
  end

  // return mux; the default slave never returns read data
  always_comb begin
    bus.HREADY = ds_hready;
    bus.HRESP  = ds_hresp;
    bus.HRDATA = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (dp_sel == SEL_W'(i)) begin
        bus.HREADY = bus.HREADYOUT_S[i];
        bus.HRESP  = bus.HRESP_S[i*HRESP_W +: HRESP_W];
        bus.HRDATA = bus.HRDATA_S[i*DATA_W +: DATA_W];
      end
    end
  end

  ahb_default_slave #(
    .HRESP_W (HRESP_W),
    .CNT_W   (CNT_W)
  ) u_default_slave (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .HREADY      (bus.HREADY),
    .miss_active (miss_active),
    .err_cnt_clr (err_cnt_clr),
    .ds_hready   (ds_hready),
    .ds_hresp    (ds_hresp),
    .err_cnt     (err_cnt)
  );

endmodule

// File: tb/tb_ahb_decode_mux.sv
// tb/tb_ahb_decode_mux.sv - scoreboard bench for ahb_decode_mux
module tb_ahb_decode_mux;
  import ahb_pkg::*;

  localparam logic [1:0] OK  = 2'd0;
  localparam logic [1:0] ERR = 2'd1;

  logic       HCLK = 1'b0;
  logic       HRESET = 1'b1;
  logic       err_cnt_clr = 1'b0;
  logic [1:0] err_cnt;
  logic [1:0] s1_wait;

  ahb_decode_mux_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(4), .HRESP_W(2)) bus ();

  ahb_decode_mux #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .NUM_SLV  (4),
    .HRESP_W  (2),
    .SLV_BASE ({32'h2100_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
    .SLV_MASK ({32'hFF00_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000}),
    .CNT_W    (2)
  ) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .bus         (bus.slave),
    .err_cnt     (err_cnt),
    .err_cnt_clr (err_cnt_clr)
  );

  always #5 HCLK = ~HCLK;

  // slave bank: fixed read data, slave 1 inserts 3 wait states per active transfer
  assign bus.HRDATA_S    = {32'h3333_0003, 32'hCAFE_F00D, 32'h1111_BEEF, 32'h0000_AAAA};
  assign bus.HRESP_S     = '0;
  assign bus.HREADYOUT_S = {1'b1, 1'b1, (s1_wait == 2'd0), 1'b1};

  always @(posedge HCLK) begin
    if (HRESET)                                          s1_wait <= 2'd0;
    else if (bus.HREADY && bus.HSEL_S[1] && bus.HTRANS[1]) s1_wait <= 2'd3;
    else if (s1_wait != 2'd0)                            s1_wait <= s1_wait - 2'd1;
  end

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    int          waits;
    logic [1:0]  cnt;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_fail = 0;
  int   mon_waits = 0;
  logic [1:0] m_cnt = 2'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // drive one address phase, hold it until accepted, then queue its expected data phase
  task automatic issue(input logic [31:0] a, input logic [1:0] t, input logic [3:0] hsel,
                       input logic [31:0] d, input logic [1:0] r, input int w,
                       input bit clr, input bit push, input int id, output int stalls);
    exp_t e;
    bus.HADDR  = a;
    bus.HTRANS = t;
    stalls     = 0;
    @(negedge HCLK);
    chk($sformatf("x%0d_hsel", id), bus.HSEL_S, hsel);
    while (bus.HREADY !== 1'b1 && stalls < 20) begin
      stalls++;
      @(negedge HCLK);
    end
    chk($sformatf("x%0d_accept", id), bus.HREADY, 1'b1);
    err_cnt_clr = clr;
    @(posedge HCLK);
    if (clr)                                   m_cnt = 2'd0;
    else if (hsel == 4'b0 && t[1] && m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
    if (push) begin
      e = '{data: d, resp: r, waits: w, cnt: m_cnt, id: id};
      sb.push_back(e);
    end
    #1;
    bus.HTRANS  = IDLE;
    err_cnt_clr = 1'b0;
  endtask

  // monitor: every completed tracked data phase pops one expectation
  always @(negedge HCLK) begin
    exp_t cur;
    if (!HRESET && sb.size() > 0) begin
      if (bus.HREADY === 1'b1) begin
        cur = sb.pop_front();
        chk($sformatf("x%0d_hrdata", cur.id), bus.HRDATA, cur.data);
        chk($sformatf("x%0d_hresp", cur.id), bus.HRESP, cur.resp);
        chk($sformatf("x%0d_waits", cur.id), mon_waits, cur.waits);
        chk($sformatf("x%0d_err_cnt", cur.id), err_cnt, cur.cnt);
        mon_waits = 0;
      end else begin
        chk($sformatf("x%0d_wait_hresp", sb[0].id), bus.HRESP, sb[0].resp);
        mon_waits++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int st;
    bus.HADDR  = 32'h9000_0000;
    bus.HTRANS = IDLE;
    repeat (2) @(posedge HCLK);
    #1 HRESET = 1'b0;
    @(negedge HCLK);
    chk("rst_hready", bus.HREADY, 1'b1);
    chk("rst_hresp", bus.HRESP, OK);
    chk("rst_hrdata", bus.HRDATA, 32'h0);
    chk("rst_err_cnt", err_cnt, 2'd0);
    @(posedge HCLK);
    #1;

    issue(32'h2000_0010, NONSEQ, 4'b0100, 32'hCAFE_F00D, OK, 0, 0, 1, 1, st);
    issue(32'h1000_0004, NONSEQ, 4'b0010, 32'h1111_BEEF, OK, 3, 0, 1, 2, st);
    issue(32'h0000_0008, NONSEQ, 4'b0001, 32'h0000_AAAA, OK, 0, 0, 1, 3, st);
    chk("s1_addr_stall", st, 3);
    issue(32'h2100_0000, NONSEQ, 4'b0100, 32'hCAFE_F00D, OK, 0, 0, 1, 4, st);
    issue(32'h9000_0000, NONSEQ, 4'b0000, 32'h0, ERR, 1, 0, 1, 5, st);
    issue(32'h9000_0000, IDLE,   4'b0000, 32'h0, OK,  0, 0, 1, 6, st);
    issue(32'h9000_0000, NONSEQ, 4'b0000, 32'h0, ERR, 1, 0, 1, 7, st);
    issue(32'h9000_0004, SEQ,    4'b0000, 32'h0, ERR, 1, 0, 1, 8, st);
    issue(32'h9000_0008, SEQ,    4'b0000, 32'h0, ERR, 1, 0, 1, 9, st);
    issue(32'hA000_0000, NONSEQ, 4'b0000, 32'h0, ERR, 1, 0, 1, 10, st);
    issue(32'h9000_0000, NONSEQ, 4'b0000, 32'h0, ERR, 1, 1, 1, 11, st);
    issue(32'h9000_0000, NONSEQ, 4'b0000, 32'h0, ERR, 1, 0, 1, 12, st);
    issue(32'h2000_0020, NONSEQ, 4'b0100, 32'hCAFE_F00D, OK, 0, 0, 1, 13, st);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge HCLK);
    chk("drain_empty", sb.size(), 0);
    @(posedge HCLK);
    #1;

    issue(32'h9000_0000, NONSEQ, 4'b0000, 32'h0, ERR, 1, 0, 0, 14, st);
    HRESET = 1'b1;
    @(negedge HCLK);
    chk("err1_hready", bus.HREADY, 1'b0);
    chk("err1_hresp", bus.HRESP, ERR);
    chk("err1_err_cnt", err_cnt, m_cnt);
    @(posedge HCLK);
    #1 HRESET = 1'b0;
    m_cnt = 2'd0;
    @(negedge HCLK);
    chk("abort_hready", bus.HREADY, 1'b1);
    chk("abort_hresp", bus.HRESP, OK);
    chk("abort_hrdata", bus.HRDATA, 32'h0);
    chk("abort_err_cnt", err_cnt, m_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
